instr_exec_unit: RTL and testbench

Execution stage directly downstream of `instr_register`. On a start command it walks a contiguous range of instruction register locations by driving `read_pointer`, captures each `instruction_word`, and executes the opcode on the signed operands. Each result is presented on a valid/ready output port with its source address. The block is the consumer of everything the instruction register stores; results go to the result checker or writeback logic.

---
 rtl/instr_register_pkg.sv | 20 ++
 rtl/instr_exec_unit.sv | 152 +++++++++++++++
 tb/tb_instr_exec_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
package instr_register_pkg;
  typedef logic [3:0]         opcode_t;
  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam opcode_t OPC_ZERO  = 4'd0;
  localparam opcode_t OPC_PASSA = 4'd1;
  localparam opcode_t OPC_PASSB = 4'd2;
  localparam opcode_t OPC_ADD   = 4'd3;
  localparam opcode_t OPC_SUB   = 4'd4;
  localparam opcode_t OPC_MULT  = 4'd5;
  localparam opcode_t OPC_DIV   = 4'd6;
  localparam opcode_t OPC_MOD   = 4'd7;
endpackage

// File: rtl/instr_exec_unit.sv
// Walks instr_register locations first_ptr..last_ptr (wrapping at 31), executes each opcode and
// offers results on a valid/ready port. Define INSTR_EXEC_DIV_EN to build the DIV/MOD divider.
module instr_exec_unit
  import instr_register_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         first_ptr,
  input  logic [4:0]         last_ptr,
  output logic               busy,
  output logic               done,
  output logic [4:0]         read_pointer,
  input  instruction_t       instruction_word,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [63:0] res_data,
  output opcode_t            res_opc,
  output logic [4:0]         res_addr,
  output logic               res_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_OUT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         rd_ptr_q, rd_ptr_d;
  logic [4:0]         cur_ptr_q, cur_ptr_d;
  logic [4:0]         exec_addr_q, exec_addr_d;
  instruction_t       instr_q, instr_d;
  logic               valid_q, valid_d;
  logic signed [63:0] data_q, data_d;
  opcode_t            opc_q, opc_d;
  logic [4:0]         addr_q, addr_d;
  logic               err_q, err_d;

  logic signed [63:0] a_ext, b_ext, alu_res;
  logic               alu_err;

  assign a_ext = 64'($signed(instr_q.op_a));
  assign b_ext = 64'($signed(instr_q.op_b));

  // Operands are pre-extended, so the low 64 bits of the product are the exact signed result.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (instr_q.opc)
      OPC_ZERO:  alu_res = '0;
      OPC_PASSA: alu_res = a_ext;
      OPC_PASSB: alu_res = b_ext;
      OPC_ADD:   alu_res = a_ext + b_ext;
      OPC_SUB:   alu_res = a_ext - b_ext;
      OPC_MULT:  alu_res = a_ext * b_ext;
`ifdef INSTR_EXEC_DIV_EN
      OPC_DIV: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext / b_ext;
      end
      OPC_MOD: begin
        if (b_ext == '0) alu_err = 1'b1;
        else             alu_res = a_ext % b_ext;
      end
`endif
      default:   alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    cur_ptr_d   = cur_ptr_q;
    exec_addr_d = exec_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    data_d      = data_q;
    opc_d       = opc_q;
    addr_d      = addr_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          rd_ptr_d  = first_ptr;
          cur_ptr_d = first_ptr;
        end
      end
      S_FETCH: begin
        instr_d     = instruction_word;
        exec_addr_d = cur_ptr_q;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        data_d  = alu_res;
        opc_d   = instr_q.opc;
        addr_d  = exec_addr_q;
        err_d   = alu_err;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        // Result registers are untouched until the handshake, so a stall holds them stable.
        if (valid_q && res_ready) begin
          valid_d = 1'b0;
          if (cur_ptr_q == last_ptr) begin
            state_d = S_DONE;
          end else begin
            cur_ptr_d = cur_ptr_q + 5'd1;
            rd_ptr_d  = cur_ptr_q + 5'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      cur_ptr_q   <= '0;
      exec_addr_q <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      opc_q       <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      cur_ptr_q   <= cur_ptr_d;
      exec_addr_q <= exec_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      opc_q       <= opc_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign read_pointer = rd_ptr_q;
  assign res_valid    = valid_q;
  assign res_data     = data_q;
  assign res_opc      = opc_q;
  assign res_addr     = addr_q;
  assign res_err      = err_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomised bench for instr_exec_unit against a behavioural model of the opcode rules and range walk.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [4:0]         first_ptr, last_ptr;
  logic               busy, done;
  logic [4:0]         read_pointer;
  instruction_t       instruction_word;
  logic               res_valid, res_ready;
  logic signed [63:0] res_data;
  opcode_t            res_opc;
  logic [4:0]         res_addr;
  logic               res_err;

  instruction_t mem [32];
  logic [64:0]  res_log [$];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_exec_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .busy(busy), .done(done), .read_pointer(read_pointer), .instruction_word(instruction_word),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_opc(res_opc),
    .res_addr(res_addr), .res_err(res_err)
  );

  // Division computed from magnitudes so truncation toward zero follows from the definition.
  function automatic void model(input instruction_t ins, output logic [63:0] r, output logic e);
    longint a, b, q;
    a = $signed(ins.op_a);
    b = $signed(ins.op_b);
    r = '0;
    e = 1'b0;
    case (ins.opc)
      4'd0: r = '0;
      4'd1: r = a;
      4'd2: r = b;
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = a * b;
      4'd6, 4'd7: begin
`ifdef INSTR_EXEC_DIV_EN
        if (b == 0) e = 1'b1;
        else begin
          q = (a < 0 ? -a : a) / (b < 0 ? -b : b);
          if ((a < 0) != (b < 0)) q = -q;
          r = (ins.opc == 4'd6) ? q : (a - q * b);
        end
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem[i].opc  = ($urandom % 8 == 0) ? 4'($urandom_range(15, 8)) : 4'($urandom_range(7, 0));
      mem[i].op_a = ($urandom % 2 == 0) ? $urandom : 32'($signed(8'($urandom)));
      mem[i].op_b = ($urandom % 6 == 0) ? 32'd0 :
                    ($urandom % 2 == 0) ? $urandom : 32'($signed(8'($urandom)));
    end
  endtask

  // Starts a walk and checks every cycle until busy drops; stall_first stalls the first result.
  task automatic run_seq(input logic [4:0] f, input logic [4:0] l, input int stall_first, input bit rand_stall);
    int n, idx, cyc, vcyc, stall;
    logic [4:0]  a;
    logic [63:0] er;
    logic        ee;
    n = ((int'(l) - int'(f)) & 31) + 1;
    idx = 0; cyc = 0; vcyc = 3; stall = stall_first;
    res_log.delete();
    first_ptr = f; last_ptr = l; res_ready = 1'b0; start = 1'b1;
    @(negedge clk); cyc = 1; start = 1'b0;
    vecs++;
    if (read_pointer !== f || busy !== 1'b1) begin
      errs++; $display("FAIL start_capture: read_pointer=%0d busy=%0b, want %0d/1", read_pointer, busy, f);
    end
    while (idx < n) begin
      a = f + 5'(idx);
      vecs++;
      if (res_valid !== (cyc >= vcyc) || done !== 1'b0 || busy !== 1'b1) begin
        errs++; $display("FAIL timing: cyc=%0d res_valid=%0b done=%0b busy=%0b, want valid=%0b done=0 busy=1",
                         cyc, res_valid, done, busy, cyc >= vcyc);
      end
      if (cyc >= vcyc) begin
        model(mem[a], er, ee);
        vecs++;
        if (res_data !== er || res_err !== ee || res_opc !== mem[a].opc || res_addr !== a || read_pointer !== a) begin
          errs++; $display("FAIL result: addr=%0d/rp=%0d data=%0h err=%0b opc=%0d, want addr=rp=%0d data=%0h err=%0b opc=%0d",
                           res_addr, read_pointer, res_data, res_err, res_opc, a, er, ee, mem[a].opc);
        end
        if (stall > 0) begin
          res_ready = 1'b0;
          stall--;
        end else begin
          res_ready = 1'b1;
          res_log.push_back({res_err, res_data});
          idx++;
          vcyc = cyc + 3;
          stall = rand_stall ? $urandom_range(3, 0) : 0;
        end
      end else begin
        res_ready = 1'($urandom);
      end
      start = 1'($urandom);
      if (cyc > 600) begin
        errs++; $display("FAIL timeout: %0d of %0d results after %0d cycles", idx, n, cyc);
        break;
      end
      @(negedge clk); cyc++;
    end
    res_ready = 1'b0;
    start = 1'b0;
    vecs++;
    if (done !== 1'b1 || res_valid !== 1'b0) begin
      errs++; $display("FAIL done_pulse: done=%0b res_valid=%0b, want 1/0", done, res_valid);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL done_clear: done=%0b busy=%0b, want 0/0", done, busy);
    end
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL start_during_done: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b0; first_ptr = '0; last_ptr = '0;
    repeat (2) @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || read_pointer !== 5'd0 || res_valid !== 1'b0) begin
      errs++; $display("FAIL reset_ctrl: busy=%0b done=%0b rp=%0d valid=%0b, want all 0", busy, done, read_pointer, res_valid);
    end
    vecs++;
    if (res_data !== 64'd0 || res_opc !== 4'd0 || res_addr !== 5'd0 || res_err !== 1'b0) begin
      errs++; $display("FAIL reset_data: data=%0h opc=%0d addr=%0d err=%0b, want all 0", res_data, res_opc, res_addr, res_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL reset_release: busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_single_entry();
    mem[0] = '{opc: 4'd3, op_a: -32'sd15, op_b: 32'sd7};
    run_seq(5'd0, 5'd0, 0, 1'b0);
    vecs++;
    if (res_log.size() != 1 || res_log[0] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFF8}) begin
      errs++; $display("FAIL single_entry: %0d results, first=%0h, want 1 result 0_fffffffffffffff8",
                       res_log.size(), res_log.size() > 0 ? res_log[0] : 65'd0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 32; i++) mem[i] = '{opc: 4'd5, op_a: -32'sd3, op_b: 32'sd5};
    run_seq(5'd30, 5'd1, 0, 1'b0);
    vecs++;
    if (res_log.size() != 4 || res_log[3] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFF1}) begin
      errs++; $display("FAIL wrap: %0d results, last=%0h, want 4 results of -15",
                       res_log.size(), res_log.size() > 0 ? res_log[res_log.size()-1] : 65'd0);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_seq(5'd3, 5'd4, 5, 1'b0);
    run_seq(5'd17, 5'd22, 2, 1'b1);
  endtask

  task automatic test_errors();
    mem[0] = '{opc: 4'd6, op_a: 32'sd9, op_b: 32'sd0};
    mem[1] = '{opc: 4'd7, op_a: -32'sd7, op_b: 32'sd3};
    mem[2] = '{opc: 4'd12, op_a: 32'sd4, op_b: 32'sd4};
    run_seq(5'd0, 5'd2, 0, 1'b0);
    vecs++;
    if (res_log.size() != 3 || res_log[0] !== {1'b1, 64'd0} || res_log[2] !== {1'b1, 64'd0}) begin
      errs++; $display("FAIL div_zero_illegal: %0d results, want div0 and illegal both 1_0", res_log.size());
    end
    vecs++;
`ifdef INSTR_EXEC_DIV_EN
    if (res_log.size() != 3 || res_log[1] !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errs++; $display("FAIL mod_neg: got %0h, want 0_ffffffffffffffff", res_log.size() > 1 ? res_log[1] : 65'd0);
    end
`else
    if (res_log.size() != 3 || res_log[1] !== {1'b1, 64'd0}) begin
      errs++; $display("FAIL mod_disabled: got %0h, want 1_0", res_log.size() > 1 ? res_log[1] : 65'd0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    fill_random();
    first_ptr = 5'd5; last_ptr = 5'd7; res_ready = 1'b1; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (done !== 1'b0) begin
        errs++; $display("FAIL reset_mid_done: done=%0b, want 0", done);
      end
    end
    vecs++;
    if (read_pointer !== 5'd6 || res_valid !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL reset_mid_pos: rp=%0d valid=%0b busy=%0b, want 6/0/1", read_pointer, res_valid, busy);
    end
    reset_n = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0 || read_pointer !== 5'd0 || res_valid !== 1'b0 ||
        res_data !== 64'd0 || res_addr !== 5'd0 || res_opc !== 4'd0 || res_err !== 1'b0) begin
      errs++; $display("FAIL reset_async: busy=%0b done=%0b rp=%0d valid=%0b data=%0h addr=%0d, want all 0",
                       busy, done, read_pointer, res_valid, res_data, res_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset_mid_idle: busy=%0b done=%0b, want 0/0", busy, done);
    end
    run_seq(5'd5, 5'd7, 0, 1'b1);
  endtask

  task automatic test_random();
    repeat (6) begin
      fill_random();
      run_seq(5'($urandom), 5'($urandom), 0, 1'b1);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b0; first_ptr = '0; last_ptr = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_single_entry();
    test_wrap();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
